riscv_bus_checker: RTL and testbench

Parametrised memory-bus responder and write checker for the RISC-V validation bench. It sits on the core's native memory port. Instruction and data reads are served from an internal program RAM. Every store is compared in order against a programmable list of expected writes, with byte-lane masking, error counting and first-failure capture. It supersedes the fixed 16-bit, zero-latency checker with configurable widths, depths and response latency.

---
 rtl/riscv_val_pkg.sv | 38 +++
 rtl/val_sync_ram.sv | 24 ++
 rtl/riscv_bus_checker.sv | 183 ++++++++++++++++++
 tb/tb_riscv_bus_checker.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_val_pkg.sv
// Shared types and helpers for the RISC-V validation bus checker.
// Expected-write entries are carried at the widest supported bus and zero-extended from narrower ones.
package riscv_val_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int MAX_ADDR_W = 32;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] data;
        logic [MAX_STRB_W-1:0] strb;
    } exp_entry_t;

    function automatic logic masked_equal(input logic [MAX_DATA_W-1:0] a,
                                          input logic [MAX_DATA_W-1:0] b,
                                          input logic [MAX_STRB_W-1:0] strb);
        logic eq;
        eq = 1'b1;
        for (int i = 0; i < MAX_STRB_W; i++) begin
            if (strb[i] && (a[8*i +: 8] != b[8*i +: 8])) begin
                eq = 1'b0;
            end
        end
        return eq;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/val_sync_ram.sv
// Single write port, single synchronous read port RAM; contents survive reset.
module val_sync_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/riscv_bus_checker.sv
// Memory-bus responder: serves reads from a program RAM after READY_LAT cycles and
// checks every store, in order, against a loaded list of expected writes.
module riscv_bus_checker
    import riscv_val_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int PROG_DEPTH = 256,
    parameter int EXP_DEPTH  = 64,
    parameter int READY_LAT  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_valid,
    input  logic                     mem_instr,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W/8-1:0]      mem_wstrb,
    output logic                     mem_ready,
    output logic [DATA_W-1:0]        mem_rdata,
    input  logic                     ld_en,
    input  logic                     ld_sel,
    input  logic [$clog2((EXP_DEPTH > PROG_DEPTH) ? EXP_DEPTH : PROG_DEPTH)-1:0] ld_idx,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic [DATA_W/8-1:0]      ld_strb,
    input  logic [$clog2(EXP_DEPTH):0] exp_count,
    output logic                     done,
    output logic                     pass,
    output logic [15:0]              err_count,
    output logic [15:0]              wr_count,
    output logic [15:0]              fetch_count,
    output logic [$clog2(EXP_DEPTH):0] fail_idx,
    output logic [ADDR_W-1:0]        fail_addr,
    output logic [DATA_W-1:0]        fail_data
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int BYTE_SH = $clog2(STRB_W);
    localparam int PROG_AW = $clog2(PROG_DEPTH);
    localparam int EXP_AW  = $clog2(EXP_DEPTH);
    localparam int CNT_W   = EXP_AW + 1;
    localparam int LAT_W   = (READY_LAT > 1) ? $clog2(READY_LAT) : 1;
    localparam int EXP_W   = ADDR_W + DATA_W + STRB_W;

    state_t             state, state_nx;
    logic [LAT_W-1:0]   lat_cnt, lat_cnt_nx;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [STRB_W-1:0]  lat_wstrb;
    logic               lat_instr;
    logic [CNT_W-1:0]   wptr, wptr_nx;
    logic [PROG_AW-1:0] prog_raddr;
    logic [DATA_W-1:0]  prog_q;
    logic [EXP_W-1:0]   exp_q;
    exp_entry_t         exp_view;
    logic               is_write;
    logic               prog_hit;
    logic               mismatch;

    // Program RAM is addressed straight from the bus at accept, then held on the latched address.
    assign prog_raddr = (state == IDLE) ? mem_addr[BYTE_SH +: PROG_AW] : lat_addr[BYTE_SH +: PROG_AW];

    val_sync_ram #(
        .WIDTH(DATA_W),
        .DEPTH(PROG_DEPTH)
    ) u_prog_ram (
        .clk   (clk),
        .we    (ld_en && !ld_sel),
        .waddr (ld_idx[PROG_AW-1:0]),
        .wdata (ld_data),
        .raddr (prog_raddr),
        .rdata (prog_q)
    );

    val_sync_ram #(
        .WIDTH(EXP_W),
        .DEPTH(EXP_DEPTH)
    ) u_exp_ram (
        .clk   (clk),
        .we    (ld_en && ld_sel),
        .waddr (ld_idx[EXP_AW-1:0]),
        .wdata ({ld_addr, ld_data, ld_strb}),
        .raddr (wptr[EXP_AW-1:0]),
        .rdata (exp_q)
    );

    always_comb begin
        state_nx   = state;
        lat_cnt_nx = lat_cnt;
        mem_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    lat_cnt_nx = LAT_W'(READY_LAT - 1);
                    state_nx   = (READY_LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!mem_valid) begin
                    state_nx = IDLE;
                end else begin
                    lat_cnt_nx = lat_cnt - LAT_W'(1);
                    if (lat_cnt <= LAT_W'(1)) begin
                        state_nx = RESP;
                    end
                end
            end
            RESP: begin
                mem_ready = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A store past the end of the list is always an error, whatever the RAM returns.
    always_comb begin
        exp_view.addr = MAX_ADDR_W'(exp_q[EXP_W-1 -: ADDR_W]);
        exp_view.data = MAX_DATA_W'(exp_q[STRB_W +: DATA_W]);
        exp_view.strb = MAX_STRB_W'(exp_q[STRB_W-1:0]);
        is_write      = |lat_wstrb;
        prog_hit      = (lat_addr >> (BYTE_SH + PROG_AW)) == '0;
        mismatch      = (wptr >= exp_count)
                     || (exp_view.addr != MAX_ADDR_W'(lat_addr))
                     || (exp_view.strb != MAX_STRB_W'(lat_wstrb))
                     || !masked_equal(MAX_DATA_W'(lat_wdata), exp_view.data, exp_view.strb);
        wptr_nx       = (&wptr) ? wptr : wptr + CNT_W'(1);
        mem_rdata     = (state == RESP && !is_write && prog_hit) ? prog_q : '0;
    end

    assign pass = done && (err_count == 16'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_wstrb   <= '0;
            lat_instr   <= 1'b0;
            wptr        <= '0;
            done        <= 1'b0;
            err_count   <= '0;
            wr_count    <= '0;
            fetch_count <= '0;
            fail_idx    <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
        end else begin
            state   <= state_nx;
            lat_cnt <= lat_cnt_nx;
            if (state == IDLE && mem_valid) begin
                lat_addr  <= mem_addr;
                lat_wdata <= mem_wdata;
                lat_wstrb <= mem_wstrb;
                lat_instr <= mem_instr;
            end
            if (state == RESP) begin
                if (lat_instr) begin
                    fetch_count <= sat_inc16(fetch_count);
                end
                if (is_write) begin
                    wr_count <= sat_inc16(wr_count);
                    wptr     <= wptr_nx;
                    if (wptr_nx == exp_count) begin
                        done <= 1'b1;
                    end
                    // The error count never returns to zero, so zero marks the first failure.
                    if (mismatch) begin
                        err_count <= sat_inc16(err_count);
                        if (err_count == 16'd0) begin
                            fail_idx  <= wptr;
                            fail_addr <= lat_addr;
                            fail_data <= lat_wdata;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_bus_checker.sv
// Self-checking bench: two checkers (latency 1 and 4) against a transaction-level model.
module tb_riscv_bus_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_instr;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        ld_en;
    logic        ld_sel;
    logic [7:0]  ld_idx;
    logic [15:0] ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  ld_strb;
    logic [6:0]  exp_count;

    logic        dut_valid [2];
    logic        dut_ready [2];
    logic [31:0] dut_rdata [2];
    logic        dut_done  [2];
    logic        dut_pass  [2];
    logic [15:0] dut_err   [2];
    logic [15:0] dut_wr    [2];
    logic [15:0] dut_fetch [2];
    logic [6:0]  dut_fidx  [2];
    logic [15:0] dut_faddr [2];
    logic [31:0] dut_fdata [2];

    logic [31:0] m_prog     [256];
    logic [15:0] m_exp_addr [64];
    logic [31:0] m_exp_data [64];
    logic [3:0]  m_exp_strb [64];
    int          m_wptr  [2];
    logic [15:0] m_err   [2];
    logic [15:0] m_wr    [2];
    logic [15:0] m_fetch [2];
    logic        m_done  [2];
    int          m_fidx  [2];
    logic [15:0] m_faddr [2];
    logic [31:0] m_fdata [2];
    logic        busy    [2];

    int   checks = 0;
    int   errors = 0;
    logic cmp_en = 1'b0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    riscv_bus_checker #(.READY_LAT(1)) u_dut_lat1 (
        .clk(clk), .reset(reset),
        .mem_valid(dut_valid[0]), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(dut_ready[0]), .mem_rdata(dut_rdata[0]),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_idx(ld_idx), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_strb(ld_strb), .exp_count(exp_count),
        .done(dut_done[0]), .pass(dut_pass[0]), .err_count(dut_err[0]),
        .wr_count(dut_wr[0]), .fetch_count(dut_fetch[0]), .fail_idx(dut_fidx[0]),
        .fail_addr(dut_faddr[0]), .fail_data(dut_fdata[0])
    );

    riscv_bus_checker #(.READY_LAT(4)) u_dut_lat4 (
        .clk(clk), .reset(reset),
        .mem_valid(dut_valid[1]), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(dut_ready[1]), .mem_rdata(dut_rdata[1]),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_idx(ld_idx), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_strb(ld_strb), .exp_count(exp_count),
        .done(dut_done[1]), .pass(dut_pass[1]), .err_count(dut_err[1]),
        .wr_count(dut_wr[1]), .fetch_count(dut_fetch[1]), .fail_idx(dut_fidx[1]),
        .fail_addr(dut_faddr[1]), .fail_data(dut_fdata[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_wptr[d] = 0; m_err[d] = '0; m_wr[d] = '0; m_fetch[d] = '0;
            m_done[d] = 1'b0; m_fidx[d] = 0; m_faddr[d] = '0; m_fdata[d] = '0;
            busy[d] = 1'b0;
        end
    endtask

    task automatic model_complete(input int d, input logic instr, input logic [15:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] wstrb);
        logic bad;
        int   idx;
        if (instr && m_fetch[d] != 16'hFFFF) m_fetch[d]++;
        if (wstrb != 4'h0) begin
            if (m_wr[d] != 16'hFFFF) m_wr[d]++;
            idx = m_wptr[d];
            if (idx >= int'(exp_count)) bad = 1'b1;
            else bad = (addr != m_exp_addr[idx]) || (wstrb != m_exp_strb[idx])
                    || (((wdata ^ m_exp_data[idx]) & lane_mask(wstrb)) != 32'h0);
            if (bad) begin
                if (m_err[d] == 16'h0) begin
                    m_fidx[d] = idx; m_faddr[d] = addr; m_fdata[d] = wdata;
                end
                if (m_err[d] != 16'hFFFF) m_err[d]++;
            end
            if (m_wptr[d] < 127) m_wptr[d]++;
            if (m_wptr[d] == int'(exp_count)) m_done[d] = 1'b1;
        end
    endtask

    task automatic load_prog(input int idx, input logic [31:0] w);
        @(negedge clk);
        ld_en = 1'b1; ld_sel = 1'b0; ld_idx = 8'(idx); ld_data = w;
        @(negedge clk);
        ld_en = 1'b0;
        m_prog[idx] = w;
    endtask

    task automatic load_exp(input int idx, input logic [15:0] a, input logic [31:0] w, input logic [3:0] s);
        @(negedge clk);
        ld_en = 1'b1; ld_sel = 1'b1; ld_idx = 8'(idx); ld_addr = a; ld_data = w; ld_strb = s;
        @(negedge clk);
        ld_en = 1'b0;
        m_exp_addr[idx] = a; m_exp_data[idx] = w; m_exp_strb[idx] = s;
    endtask

    task automatic applyStimulus(input int d, input logic instr, input logic [15:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 output logic [31:0] rdata_seen);
        int          cyc;
        logic        seen;
        logic [31:0] exp_rd;
        @(negedge clk);
        mem_instr = instr; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
        dut_valid[d] = 1'b1;
        @(posedge clk);
        busy[d] = 1'b1;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < lat_of(d) + 4) begin
            @(negedge clk);
            cyc++;
            if (dut_ready[d]) seen = 1'b1;
        end
        checkOutput($sformatf("lat%0d.ready_seen", lat_of(d)), 64'(seen), 64'(1));
        rdata_seen = '0;
        if (!seen) begin
            dut_valid[d] = 1'b0;
            busy[d] = 1'b0;
        end else begin
            checkOutput($sformatf("lat%0d.latency", lat_of(d)), 64'(cyc), 64'(lat_of(d)));
            if (wstrb != 4'h0) exp_rd = 32'h0;
            else if ((addr >> 2) < 16'd256) exp_rd = m_prog[addr >> 2];
            else exp_rd = 32'h0;
            checkOutput($sformatf("lat%0d.rdata@%0h", lat_of(d), addr), 64'(dut_rdata[d]), 64'(exp_rd));
            rdata_seen = dut_rdata[d];
            dut_valid[d] = 1'b0;
            @(posedge clk);
            #1;
            model_complete(d, instr, addr, wdata, wstrb);
            busy[d] = 1'b0;
        end
    endtask

    // Status outputs follow the model every cycle; an idle port must keep ready and rdata low.
    always @(negedge clk) begin
        if (cmp_en && reset) begin
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("lat%0d.done", lat_of(d)), 64'(dut_done[d]), 64'(m_done[d]));
                checkOutput($sformatf("lat%0d.pass", lat_of(d)), 64'(dut_pass[d]),
                            64'(m_done[d] && (m_err[d] == 16'h0)));
                checkOutput($sformatf("lat%0d.err_count", lat_of(d)), 64'(dut_err[d]), 64'(m_err[d]));
                checkOutput($sformatf("lat%0d.wr_count", lat_of(d)), 64'(dut_wr[d]), 64'(m_wr[d]));
                checkOutput($sformatf("lat%0d.fetch_count", lat_of(d)), 64'(dut_fetch[d]), 64'(m_fetch[d]));
                checkOutput($sformatf("lat%0d.fail_idx", lat_of(d)), 64'(dut_fidx[d]), 64'(m_fidx[d]));
                checkOutput($sformatf("lat%0d.fail_addr", lat_of(d)), 64'(dut_faddr[d]), 64'(m_faddr[d]));
                checkOutput($sformatf("lat%0d.fail_data", lat_of(d)), 64'(dut_fdata[d]), 64'(m_fdata[d]));
                if (!busy[d]) begin
                    checkOutput($sformatf("lat%0d.idle_ready", lat_of(d)), 64'(dut_ready[d]), 64'(0));
                    checkOutput($sformatf("lat%0d.idle_rdata", lat_of(d)), 64'(dut_rdata[d]), 64'(0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at time %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        ld_en = 1'b0; ld_sel = 1'b0; ld_idx = '0; ld_addr = '0; ld_data = '0; ld_strb = '0;
        exp_count = 7'd2;
        dut_valid[0] = 1'b0;
        dut_valid[1] = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        load_prog(0, 32'h00000013);
        load_prog(1, 32'h00100093);
        load_prog(2, 32'h00200113);
        load_prog(3, 32'h00300193);
        load_exp(0, 16'h0100, 32'hDEADBEEF, 4'hF);
        load_exp(1, 16'h0200, 32'h0000BEEF, 4'h3);

        checkOutput("reset.mem_ready", 64'(dut_ready[0]), 64'(0));
        checkOutput("reset.done", 64'(dut_done[1]), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        cmp_en = 1'b1;

        $display("[TB] fetches, reads and in-order stores on the latency-1 checker");
        applyStimulus(0, 1'b1, 16'h0000, 32'h0, 4'h0, rd);
        checkOutput("a.fetch0_rdata", 64'(rd), 64'h00000013);
        applyStimulus(0, 1'b1, 16'h0004, 32'h0, 4'h0, rd);
        checkOutput("a.fetch1_rdata", 64'(rd), 64'h00100093);
        checkOutput("a.fetch_count", 64'(dut_fetch[0]), 64'd2);
        applyStimulus(0, 1'b0, 16'h0008, 32'h0, 4'h0, rd);
        checkOutput("a.read2_rdata", 64'(rd), 64'h00200113);
        applyStimulus(0, 1'b0, 16'h0400, 32'h0, 4'h0, rd);
        checkOutput("a.read_oob_rdata", 64'(rd), 64'h0);
        checkOutput("a.fetch_count_data", 64'(dut_fetch[0]), 64'd2);
        applyStimulus(0, 1'b0, 16'h0100, 32'hDEADBEEF, 4'hF, rd);
        checkOutput("a.done_after_1", 64'(dut_done[0]), 64'd0);
        applyStimulus(0, 1'b0, 16'h0200, 32'h1234BEEF, 4'h3, rd);
        checkOutput("a.done", 64'(dut_done[0]), 64'd1);
        checkOutput("a.pass", 64'(dut_pass[0]), 64'd1);
        checkOutput("a.err_count", 64'(dut_err[0]), 64'd0);
        applyStimulus(0, 1'b0, 16'h0300, 32'h00000055, 4'hF, rd);
        checkOutput("a.extra_err", 64'(dut_err[0]), 64'd1);
        checkOutput("a.extra_pass", 64'(dut_pass[0]), 64'd0);
        checkOutput("a.extra_fidx", 64'(dut_fidx[0]), 64'd2);
        checkOutput("a.extra_faddr", 64'(dut_faddr[0]), 64'h0300);
        checkOutput("a.wr_count", 64'(dut_wr[0]), 64'd3);

        $display("[TB] address/strobe mismatches, latency 4 and abandoned request");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        load_exp(0, 16'h0100, 32'h0000BEEF, 4'h3);
        @(negedge clk);
        reset = 1'b1;
        checkOutput("b.reset_wr", 64'(dut_wr[0]), 64'd0);
        applyStimulus(0, 1'b0, 16'h0104, 32'h1234BEEF, 4'h3, rd);
        checkOutput("b.err", 64'(dut_err[0]), 64'd1);
        checkOutput("b.fidx", 64'(dut_fidx[0]), 64'd0);
        checkOutput("b.faddr", 64'(dut_faddr[0]), 64'h0104);
        checkOutput("b.fdata", 64'(dut_fdata[0]), 64'h1234BEEF);

        applyStimulus(1, 1'b1, 16'h0004, 32'h0, 4'h0, rd);
        checkOutput("b.lat4_rdata", 64'(rd), 64'h00100093);

        @(negedge clk);
        mem_instr = 1'b0; mem_addr = 16'h0100; mem_wdata = 32'h0000BEEF; mem_wstrb = 4'h3;
        dut_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b.abandon_c1_ready", 64'(dut_ready[1]), 64'd0);
        @(negedge clk);
        dut_valid[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("b.abandon_ready", 64'(dut_ready[1]), 64'd0);
        end
        checkOutput("b.abandon_wr", 64'(dut_wr[1]), 64'd0);

        applyStimulus(1, 1'b0, 16'h0100, 32'hFFFFBEEF, 4'h3, rd);
        checkOutput("b.masked_err", 64'(dut_err[1]), 64'd0);
        applyStimulus(1, 1'b0, 16'h0200, 32'h0000BEEF, 4'hF, rd);
        checkOutput("b.strb_err", 64'(dut_err[1]), 64'd1);
        checkOutput("b.strb_fidx", 64'(dut_fidx[1]), 64'd1);
        checkOutput("b.strb_done", 64'(dut_done[1]), 64'd1);
        checkOutput("b.strb_pass", 64'(dut_pass[1]), 64'd0);

        $display("[TB] reset while waiting for ready");
        @(negedge clk);
        mem_instr = 1'b1; mem_addr = 16'h000C; mem_wdata = '0; mem_wstrb = 4'h0;
        dut_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("d.reset_ready", 64'(dut_ready[1]), 64'd0);
        checkOutput("d.reset_err", 64'(dut_err[1]), 64'd0);
        checkOutput("d.reset_wr", 64'(dut_wr[1]), 64'd0);
        checkOutput("d.reset_fetch", 64'(dut_fetch[0]), 64'd0);
        dut_valid[1] = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1, 1'b1, 16'h000C, 32'h0, 4'h0, rd);
        checkOutput("d.fetch_rdata", 64'(rd), 64'h00300193);
        checkOutput("d.fetch_count", 64'(dut_fetch[1]), 64'd1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
